// File: rtl/ddr3_traffic_checker_if.sv
// Request/response bus between the DDR3 traffic checker (master) and the
// memory controller user port (slave).
interface ddr3_traffic_checker_if #(
  parameter int ADDRESS_BITWIDTH      = 15,
  parameter int BANK_ADDRESS_BITWIDTH = 3,
  parameter int DQ_BITWIDTH           = 16
);
  localparam int AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;

  logic                   write_enable;
  logic                   read_enable;
  logic [AW-1:0]          i_user_data_address;
  logic [DQ_BITWIDTH-1:0] i_user_data;
  logic                   ctrl_ready;
  logic [DQ_BITWIDTH-1:0] o_user_data;
  logic                   o_user_data_valid;

  modport master (
    output write_enable, read_enable, i_user_data_address, i_user_data,
    input  ctrl_ready, o_user_data, o_user_data_valid
  );

  modport slave (
    input  write_enable, read_enable, i_user_data_address, i_user_data,
    output ctrl_ready, o_user_data, o_user_data_valid
  );
endinterface

// File: rtl/ddr3_traffic_checker.sv
// Write-then-read-back pattern checker for the DDR3 controller user port.
// Define DDR3_TG_LFSR_EN to use an LFSR data pattern instead of address^mask.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | waiting for start after reset
// S_WRITE     | presenting pattern writes to addresses 0..NUM_WORDS-1
// S_READ_REQ  | presenting a read request for addr
// S_READ_WAIT | one read outstanding; compare on valid or fail on timeout
// S_DONE      | results held until the next start
module ddr3_traffic_checker #(
  parameter int          ADDRESS_BITWIDTH      = 15,
  parameter int          BANK_ADDRESS_BITWIDTH = 3,
  parameter int          DQ_BITWIDTH           = 16,
  parameter int          NUM_WORDS             = 256,
  parameter logic [15:0] PATTERN_XOR           = 16'hA5A5,
  parameter int          READ_TIMEOUT          = 1023
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            start,
  ddr3_traffic_checker_if.master                          bus,
  output logic                                            busy,
  output logic                                            done,
  output logic                                            pass,
  output logic [15:0]                                     error_count,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address,
  output logic                                            timeout
);
  localparam int AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
  localparam int TW = (READ_TIMEOUT < 2) ? 1 : $clog2(READ_TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WORDS - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(READ_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ_REQ, S_READ_WAIT, S_DONE
  } state_t;

  state_t                 state;
  logic [AW-1:0]          addr;
  logic [TW-1:0]          wait_cnt;
  logic [DQ_BITWIDTH-1:0] pattern;
  logic                   start_run;
  logic                   write_accept;
  logic                   read_accept;
  logic                   read_valid;
  logic                   read_timeout;
  logic                   compare_done;
  logic                   word_error;
  logic [15:0]            error_count_next;

  assign start_run    = start && (state == S_IDLE || state == S_DONE);
  assign write_accept = bus.write_enable && bus.ctrl_ready;
  assign read_accept  = bus.read_enable && bus.ctrl_ready;
  // Data arriving on the limit cycle wins over the timeout.
  assign read_valid   = (state == S_READ_WAIT) && bus.o_user_data_valid;
  assign read_timeout = (state == S_READ_WAIT) && !bus.o_user_data_valid && (wait_cnt == '0);
  assign compare_done = read_valid || read_timeout;
  assign word_error   = read_timeout || (read_valid && (bus.o_user_data != pattern));
  assign error_count_next = (word_error && error_count != 16'hFFFF) ?
                            error_count + 16'd1 : error_count;

`ifdef DDR3_TG_LFSR_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;

  assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign pattern   = DQ_BITWIDTH'(lfsr ^ PATTERN_XOR);

  // Reseeded before the read pass so the expected stream replays the writes.
  always_ff @(posedge clk) begin
    if (reset)
      lfsr <= LFSR_SEED;
    else if (start_run)
      lfsr <= LFSR_SEED;
    else if (write_accept)
      lfsr <= (addr == LAST_ADDR) ? LFSR_SEED : lfsr_next;
    else if (compare_done)
      lfsr <= lfsr_next;
  end
`else
  assign pattern = DQ_BITWIDTH'(addr) ^ DQ_BITWIDTH'(PATTERN_XOR);
`endif

  assign bus.i_user_data_address = (bus.write_enable || bus.read_enable) ? addr : '0;
  assign bus.i_user_data         = bus.write_enable ? pattern : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= S_IDLE;
      addr                <= '0;
      wait_cnt            <= '0;
      bus.write_enable    <= 1'b0;
      bus.read_enable     <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      pass                <= 1'b0;
      error_count         <= '0;
      first_error_address <= '0;
      timeout             <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_run) begin
            error_count         <= '0;
            first_error_address <= '0;
            timeout             <= 1'b0;
            done                <= 1'b0;
            pass                <= 1'b0;
            addr                <= '0;
            busy                <= 1'b1;
            bus.write_enable    <= 1'b1;
            state               <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (write_accept) begin
            if (addr == LAST_ADDR) begin
              addr             <= '0;
              bus.write_enable <= 1'b0;
              bus.read_enable  <= 1'b1;
              state            <= S_READ_REQ;
            end else begin
              addr <= addr + AW'(1);
            end
          end
        end
        S_READ_REQ: begin
          if (read_accept) begin
            bus.read_enable <= 1'b0;
            wait_cnt        <= TIMEOUT_LOAD;
            state           <= S_READ_WAIT;
          end
        end
        S_READ_WAIT: begin
          if (compare_done) begin
            error_count <= error_count_next;
            if (word_error && error_count == 16'd0)
              first_error_address <= addr;
            if (read_timeout)
              timeout <= 1'b1;
            if (addr == LAST_ADDR) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (error_count_next == 16'd0);
              state <= S_DONE;
            end else begin
              addr            <= addr + AW'(1);
              bus.read_enable <= 1'b1;
              state           <= S_READ_REQ;
            end
          end else begin
            wait_cnt <= wait_cnt - TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
